mem_port_arbiter: RTL and testbench

- Shares one single-port unified memory between the instruction-fetch port (I) and the MEM-stage data port (D) of the pipelined CPU.
- Serialises accesses with fixed memory latency and returns read data and a completion pulse to the winning requester.
- Exports stall signals that feed the hazard unit (stallF/stallD from I, pipeline freeze from D).
- Priority goes to D (the older instruction), with an anti-starvation limit for I.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_port_arbiter_arb_pick.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and counter widths for the unified-memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned LAT_W    = 3;
    localparam int unsigned STREAK_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_I,
        OWN_D
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Winner selection between fetch (I) and data (D) ports, D-first with an
// anti-starvation streak limit, plus the streak counter's next value.
module arb_pick
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_DSTREAK = 4
) (
    input  logic                i_req,
    input  logic                d_req,
    input  logic [STREAK_W-1:0] dstreak,
    output logic                grant_i,
    output logic                grant_d,
    output logic [STREAK_W-1:0] dstreak_nxt
);

    logic streak_full;

    assign streak_full = (dstreak == STREAK_W'(MAX_DSTREAK));

    always_comb begin
        grant_i     = 1'b0;
        grant_d     = 1'b0;
        dstreak_nxt = dstreak;

        if (d_req && !(i_req && streak_full)) begin
            grant_d = 1'b1;
        end else if (i_req) begin
            grant_i = 1'b1;
        end

        // Streak only counts D grants that actually made I wait.
        if (grant_i) begin
            dstreak_nxt = '0;
        end else if (grant_d) begin
            if (!i_req) begin
                dstreak_nxt = '0;
            end else if (!streak_full) begin
                dstreak_nxt = dstreak + STREAK_W'(1);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises I-fetch and D-stage accesses onto one fixed-latency single-port
// memory; returns registered read data and a one-cycle completion pulse.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32,
    parameter int unsigned MEM_LAT     = 2,
    parameter int unsigned MAX_DSTREAK = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_valid,
    output logic          i_stall,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_valid,
    output logic          d_stall,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-3:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
);

    state_t              state, state_nxt;
    owner_t              owner, owner_nxt;
    logic [LAT_W-1:0]    lat_cnt, lat_cnt_nxt;
    logic [STREAK_W-1:0] dstreak, dstreak_nxt, pick_dstreak;
    logic                is_store, is_store_nxt;
    logic                grant_i, grant_d;
    logic                m_en_nxt, m_we_nxt;
    logic                i_valid_nxt, d_valid_nxt;
    logic [AW-3:0]       m_addr_nxt;
    logic [DW-1:0]       m_wdata_nxt, i_rdata_nxt, d_rdata_nxt;

    // Byte offset within the word is irrelevant to a word-addressed memory.
    logic unused_byte_offset;
    assign unused_byte_offset = ^{i_addr[1:0], d_addr[1:0]};

    arb_pick #(
        .MAX_DSTREAK(MAX_DSTREAK)
    ) u_pick (
        .i_req      (i_req),
        .d_req      (d_req),
        .dstreak    (dstreak),
        .grant_i    (grant_i),
        .grant_d    (grant_d),
        .dstreak_nxt(pick_dstreak)
    );

    assign i_stall = i_req & ~i_valid;
    assign d_stall = d_req & ~d_valid;

    // State, counters and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            owner    <= OWN_NONE;
            lat_cnt  <= '0;
            dstreak  <= '0;
            is_store <= 1'b0;
            m_en     <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            i_rdata  <= '0;
            d_rdata  <= '0;
            i_valid  <= 1'b0;
            d_valid  <= 1'b0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            lat_cnt  <= lat_cnt_nxt;
            dstreak  <= dstreak_nxt;
            is_store <= is_store_nxt;
            m_en     <= m_en_nxt;
            m_we     <= m_we_nxt;
            m_addr   <= m_addr_nxt;
            m_wdata  <= m_wdata_nxt;
            i_rdata  <= i_rdata_nxt;
            d_rdata  <= d_rdata_nxt;
            i_valid  <= i_valid_nxt;
            d_valid  <= d_valid_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        lat_cnt_nxt  = lat_cnt;
        dstreak_nxt  = dstreak;
        is_store_nxt = is_store;
        m_en_nxt     = 1'b0;
        m_we_nxt     = 1'b0;
        m_addr_nxt   = m_addr;
        m_wdata_nxt  = m_wdata;
        i_rdata_nxt  = i_rdata;
        d_rdata_nxt  = d_rdata;
        i_valid_nxt  = 1'b0;
        d_valid_nxt  = 1'b0;

        case (state)
            IDLE: begin
                dstreak_nxt = pick_dstreak;
                if (grant_d) begin
                    owner_nxt    = OWN_D;
                    is_store_nxt = d_we;
                    m_en_nxt     = 1'b1;
                    m_we_nxt     = d_we;
                    m_addr_nxt   = d_addr[AW-1:2];
                    m_wdata_nxt  = d_wdata;
                    state_nxt    = ISSUE;
                end else if (grant_i) begin
                    owner_nxt    = OWN_I;
                    is_store_nxt = 1'b0;
                    m_en_nxt     = 1'b1;
                    m_addr_nxt   = i_addr[AW-1:2];
                    state_nxt    = ISSUE;
                end
            end
            ISSUE: begin
                // With MEM_LAT==1 this loads zero, so WAIT captures on its first cycle.
                lat_cnt_nxt = LAT_W'(MEM_LAT - 1);
                state_nxt   = WAIT;
            end
            WAIT: begin
                if (lat_cnt == '0) begin
                    if (owner == OWN_I) begin
                        i_rdata_nxt = m_rdata;
                        i_valid_nxt = 1'b1;
                    end else if (owner == OWN_D) begin
                        if (!is_store) begin
                            d_rdata_nxt = m_rdata;
                        end
                        d_valid_nxt = 1'b1;
                    end
                    state_nxt = RESP;
                end else begin
                    lat_cnt_nxt = lat_cnt - LAT_W'(1);
                end
            end
            RESP: begin
                // No arbitration here: a still-held request waits for IDLE.
                owner_nxt = OWN_NONE;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Two arbiter builds (MEM_LAT=2 and MEM_LAT=1) against a transaction-level
// timing model and behavioural memories; directed cases then random traffic.
module tb_mem_port_arbiter;

    localparam int LAT0 = 2;
    localparam int LAT1 = 1;
    localparam int MAXD = 4;

    logic        clk;
    logic [1:0]  reset, i_req, i_valid, i_stall, d_req, d_we, d_valid, d_stall, m_en, m_we;
    logic [31:0] i_addr [2];
    logic [31:0] i_rdata [2];
    logic [31:0] d_addr [2];
    logic [31:0] d_wdata [2];
    logic [31:0] d_rdata [2];
    logic [31:0] m_wdata [2];
    logic [29:0] m_addr [2];
    logic [31:0] m_rdata0, m_rdata1;

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT0), .MAX_DSTREAK(MAXD)) dut0 (
        .clk(clk), .reset(reset[0]),
        .i_req(i_req[0]), .i_addr(i_addr[0]), .i_rdata(i_rdata[0]), .i_valid(i_valid[0]), .i_stall(i_stall[0]),
        .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
        .d_rdata(d_rdata[0]), .d_valid(d_valid[0]), .d_stall(d_stall[0]),
        .m_en(m_en[0]), .m_we(m_we[0]), .m_addr(m_addr[0]), .m_wdata(m_wdata[0]), .m_rdata(m_rdata0));

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT1), .MAX_DSTREAK(MAXD)) dut1 (
        .clk(clk), .reset(reset[1]),
        .i_req(i_req[1]), .i_addr(i_addr[1]), .i_rdata(i_rdata[1]), .i_valid(i_valid[1]), .i_stall(i_stall[1]),
        .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
        .d_rdata(d_rdata[1]), .d_valid(d_valid[1]), .d_stall(d_stall[1]),
        .m_en(m_en[1]), .m_we(m_we[1]), .m_addr(m_addr[1]), .m_wdata(m_wdata[1]), .m_rdata(m_rdata1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural memories: read data is driven only during its valid cycle.
    bit          mem_ready;
    logic [31:0] mem [2][256];
    logic [7:0]  rp_v [2];
    logic [31:0] rp_d [2][8];

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int k = 0; k < 2; k++) begin
                for (int a = 0; a < 256; a++) mem[k][a] <= 32'h2002_0000 | 32'(a);
                rp_v[k] <= '0;
            end
            mem_ready <= 1'b1;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (m_en[k] && m_we[k]) mem[k][m_addr[k][7:0]] <= m_wdata[k];
                rp_v[k]    <= {rp_v[k][6:0], m_en[k] & ~m_we[k]};
                rp_d[k][0] <= mem[k][m_addr[k][7:0]];
                for (int j = 1; j < 8; j++) rp_d[k][j] <= rp_d[k][j-1];
            end
        end
    end

    assign m_rdata0 = rp_v[0][LAT0-1] ? rp_d[0][LAT0-1] : 32'hDEAD_BEEF;
    assign m_rdata1 = rp_v[1][LAT1-1] ? rp_d[1][LAT1-1] : 32'hDEAD_BEEF;

    // Transaction model: t counts cycles since the grant (0 = arbiter idle).
    int          t [2];
    int          own [2];
    logic        mwe [2];
    logic [29:0] maddr [2];
    logic [31:0] mwd [2];
    logic [31:0] eir [2];
    logic [31:0] edr [2];
    int          dstk [2];
    logic [31:0] mmem [2][256];
    bit          pend_i [2];
    bit          pend_d [2];
    logic [31:0] p_iaddr [2];
    logic [31:0] p_daddr [2];

    int total, bad, cyc;
    bit rand_mode, hold_mode;

    int          last_men [2];
    int          last_iv [2];
    int          last_dv [2];
    int          dv_cnt [2];
    logic [29:0] men_addr [2];
    logic        men_we [2];
    logic [31:0] val_ir [2];
    logic [31:0] val_dr [2];
    bit          seen_iv [2];
    bit          seen_dv [2];
    int          grant_q [$];

    function automatic int lat_of(input int k);
        return (k == 0) ? LAT0 : LAT1;
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s dut%0d cyc=%0d got=%h exp=%h", name, k, cyc, got, exp);
        end
    endtask

    task automatic model_reset(input int k);
        t[k] = 0; own[k] = 0; mwe[k] = 1'b0; maddr[k] = '0; mwd[k] = '0;
        eir[k] = '0; edr[k] = '0; dstk[k] = 0; pend_i[k] = 1'b0; pend_d[k] = 1'b0;
    endtask

    task automatic compare(input int k);
        int   L = lat_of(k);
        logic e_men, e_we, e_iv, e_dv;
        logic [29:0] e_addr;
        logic [31:0] e_ir, e_dr;
        if (reset[k]) begin
            e_men = 0; e_we = 0; e_iv = 0; e_dv = 0; e_addr = '0; e_ir = '0; e_dr = '0;
        end else begin
            e_men  = (t[k] == 1);
            e_we   = e_men && mwe[k];
            e_iv   = (t[k] == L + 2) && (own[k] == 1);
            e_dv   = (t[k] == L + 2) && (own[k] == 2);
            e_addr = maddr[k];
            e_ir   = eir[k];
            e_dr   = edr[k];
        end
        chk("m_en", k, 32'(m_en[k]), 32'(e_men));
        chk("m_we", k, 32'(m_we[k]), 32'(e_we));
        chk("m_addr", k, 32'(m_addr[k]), 32'(e_addr));
        if (e_we) chk("m_wdata", k, m_wdata[k], mwd[k]);
        chk("i_valid", k, 32'(i_valid[k]), 32'(e_iv));
        chk("d_valid", k, 32'(d_valid[k]), 32'(e_dv));
        chk("i_rdata", k, i_rdata[k], e_ir);
        chk("d_rdata", k, d_rdata[k], e_dr);
        chk("i_stall", k, 32'(i_stall[k]), 32'(i_req[k] & ~e_iv));
        chk("d_stall", k, 32'(d_stall[k]), 32'(d_req[k] & ~e_dv));
        if (pend_i[k] && i_req[k]) chk("i_addr_stable", k, i_addr[k], p_iaddr[k]);
        if (pend_d[k] && d_req[k]) chk("d_addr_stable", k, d_addr[k], p_daddr[k]);
        pend_i[k]  = i_req[k] & ~e_iv;
        pend_d[k]  = d_req[k] & ~e_dv;
        p_iaddr[k] = i_addr[k];
        p_daddr[k] = d_addr[k];
    endtask

    task automatic step(input int k);
        int L = lat_of(k);
        if (reset[k]) begin
            model_reset(k);
        end else if (t[k] == 0) begin
            if (i_req[k] || d_req[k]) begin
                if (d_req[k] && !(i_req[k] && dstk[k] == MAXD)) begin
                    own[k] = 2; mwe[k] = d_we[k]; maddr[k] = d_addr[k][31:2]; mwd[k] = d_wdata[k];
                    dstk[k] = i_req[k] ? ((dstk[k] < MAXD) ? dstk[k] + 1 : MAXD) : 0;
                end else begin
                    own[k] = 1; mwe[k] = 1'b0; maddr[k] = i_addr[k][31:2]; dstk[k] = 0;
                end
                t[k] = 1;
            end
        end else if (t[k] == 1) begin
            if (own[k] == 2 && mwe[k]) mmem[k][maddr[k][7:0]] = mwd[k];
            t[k] = 2;
        end else if (t[k] == L + 1) begin
            if (own[k] == 1) eir[k] = mmem[k][maddr[k][7:0]];
            else if (!mwe[k]) edr[k] = mmem[k][maddr[k][7:0]];
            t[k] = t[k] + 1;
        end else if (t[k] == L + 2) begin
            t[k] = 0; own[k] = 0;
        end else begin
            t[k] = t[k] + 1;
        end
    endtask

    task automatic record(input int k);
        seen_iv[k] = i_valid[k];
        seen_dv[k] = d_valid[k];
        if (m_en[k]) begin
            last_men[k] = cyc; men_addr[k] = m_addr[k]; men_we[k] = m_we[k];
            if (k == 0) grant_q.push_back((m_addr[0] >= 30'h40) ? 2 : 1);
        end
        if (i_valid[k]) begin last_iv[k] = cyc; val_ir[k] = i_rdata[k]; end
        if (d_valid[k]) begin last_dv[k] = cyc; val_dr[k] = d_rdata[k]; dv_cnt[k]++; end
    endtask

    // One clock: check and advance the model mid-cycle, then update stimulus.
    task automatic tick();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            compare(k);
            record(k);
            step(k);
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (seen_iv[k]) begin
                if (hold_mode && k == 0) i_addr[0] = i_addr[0] + 32'd4;
                else i_req[k] = 1'b0;
            end
            if (seen_dv[k]) begin
                if (hold_mode && k == 0) d_addr[0] = d_addr[0] + 32'd4;
                else d_req[k] = 1'b0;
            end
            if (rand_mode) begin
                if (!i_req[k] && $urandom_range(0, 2) == 0) begin
                    i_req[k]  = 1'b1;
                    i_addr[k] = 32'($urandom_range(0, 63)) * 32'd4 + 32'($urandom_range(0, 3));
                end
                if (!d_req[k] && $urandom_range(0, 1) == 0) begin
                    d_req[k]   = 1'b1;
                    d_we[k]    = 1'($urandom_range(0, 1));
                    d_addr[k]  = 32'($urandom_range(0, 63)) * 32'd4 + 32'($urandom_range(0, 3));
                    d_wdata[k] = $urandom;
                end
            end
        end
    endtask

    task automatic wait_valid(input int k, input bit is_d, input string name);
        bit done = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            tick();
            done = is_d ? seen_dv[k] : seen_iv[k];
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL timeout_%s dut%0d got=no_valid exp=valid", name, k);
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 80 && (i_req != '0 || d_req != '0); n++) tick();
        chk("drain_idle", 0, 32'({i_req, d_req}), 32'd0);
    endtask

    initial begin : main
        int t0, dv0;
        int exp_g [10];
        exp_g = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
        total = 0; bad = 0; cyc = 0; rand_mode = 0; hold_mode = 0;
        reset = 2'b11; i_req = '0; d_req = '0; d_we = '0;
        for (int k = 0; k < 2; k++) begin
            i_addr[k] = '0; d_addr[k] = '0; d_wdata[k] = '0;
            last_men[k] = 0; last_iv[k] = 0; last_dv[k] = 0; dv_cnt[k] = 0;
            model_reset(k);
            for (int a = 0; a < 256; a++) mmem[k][a] = 32'h2002_0000 | 32'(a);
        end
        repeat (3) tick();
        reset = 2'b00;
        tick();

        // Single I read of word 5.
        i_req[0] = 1'b1; i_addr[0] = 32'h14; t0 = cyc; dv0 = dv_cnt[0];
        wait_valid(0, 1'b0, "i_read");
        chk("ird_men_cyc", 0, 32'(last_men[0] - t0), 32'd1);
        chk("ird_men_addr", 0, 32'(men_addr[0]), 32'd5);
        chk("ird_men_we", 0, 32'(men_we[0]), 32'd0);
        chk("ird_valid_cyc", 0, 32'(last_iv[0] - t0), 32'd4);
        chk("ird_rdata", 0, val_ir[0], 32'h2002_0005);
        chk("ird_no_dvalid", 0, 32'(dv_cnt[0] - dv0), 32'd0);

        // D store then load of the same word.
        d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h54; d_wdata[0] = 32'h7; t0 = cyc;
        wait_valid(0, 1'b1, "d_store");
        chk("dst_men_we", 0, 32'(men_we[0]), 32'd1);
        chk("dst_men_addr", 0, 32'(men_addr[0]), 32'h15);
        chk("dst_valid_cyc", 0, 32'(last_dv[0] - t0), 32'd4);
        chk("dst_rdata_hold", 0, val_dr[0], 32'h0);
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h54; t0 = cyc;
        wait_valid(0, 1'b1, "d_load");
        chk("dld_valid_cyc", 0, 32'(last_dv[0] - t0), 32'd4);
        chk("dld_rdata", 0, val_dr[0], 32'h7);

        // Simultaneous requests: D first, then I.
        i_req[0] = 1'b1; i_addr[0] = 32'h20;
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h54; t0 = cyc;
        wait_valid(0, 1'b1, "both_d");
        chk("both_d_men_cyc", 0, 32'(last_men[0] - t0), 32'd1);
        chk("both_d_valid_cyc", 0, 32'(last_dv[0] - t0), 32'd4);
        wait_valid(0, 1'b0, "both_i");
        chk("both_i_men_cyc", 0, 32'(last_men[0] - t0), 32'd6);
        chk("both_i_men_addr", 0, 32'(men_addr[0]), 32'd8);
        chk("both_i_valid_cyc", 0, 32'(last_iv[0] - t0), 32'd9);
        chk("both_i_rdata", 0, val_ir[0], 32'h2002_0008);

        // Starvation: both held continuously -> DDDDI repeating.
        grant_q.delete();
        hold_mode = 1'b1;
        i_req[0] = 1'b1; i_addr[0] = 32'h40;
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h100;
        for (int n = 0; n < 120 && grant_q.size() < 10; n++) tick();
        hold_mode = 1'b0;
        drain();
        chk("starve_grants", 0, 32'(grant_q.size() >= 10), 32'd1);
        for (int j = 0; j < 10; j++) chk($sformatf("starve_g%0d", j), 0, 32'(grant_q[j]), 32'(exp_g[j]));

        // Reset during WAIT abandons the access.
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h14; dv0 = dv_cnt[0];
        tick(); tick();
        reset[0] = 1'b1;
        #1;
        chk("rst_m_en", 0, 32'(m_en[0]), 32'd0);
        chk("rst_m_we", 0, 32'(m_we[0]), 32'd0);
        chk("rst_m_addr", 0, 32'(m_addr[0]), 32'd0);
        chk("rst_d_valid", 0, 32'(d_valid[0]), 32'd0);
        chk("rst_d_rdata", 0, d_rdata[0], 32'd0);
        chk("rst_i_rdata", 0, i_rdata[0], 32'd0);
        tick();
        d_req[0] = 1'b0;
        tick();
        reset[0] = 1'b0;
        i_req[0] = 1'b1; i_addr[0] = 32'h14; t0 = cyc;
        wait_valid(0, 1'b0, "post_rst");
        chk("post_rst_valid_cyc", 0, 32'(last_iv[0] - t0), 32'd4);
        chk("post_rst_rdata", 0, val_ir[0], 32'h2002_0005);
        chk("post_rst_no_dvalid", 0, 32'(dv_cnt[0] - dv0), 32'd0);

        // MEM_LAT=1 build: single D load.
        d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'h14; t0 = cyc;
        wait_valid(1, 1'b1, "lat1_load");
        chk("lat1_men_cyc", 1, 32'(last_men[1] - t0), 32'd1);
        chk("lat1_valid_cyc", 1, 32'(last_dv[1] - t0), 32'd3);
        chk("lat1_rdata", 1, val_dr[1], 32'h2002_0005);

        // Random traffic on both builds.
        rand_mode = 1'b1;
        repeat (3000) tick();
        rand_mode = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
